sram_rd_slave: RTL and testbench
================================

Name: sram_rd_slave

Overview:
Responder (slave) end of the SRAM read interface: owns a single-clock memory array and answers rdEn/rdAddr requests with rdData after a fixed, parameterised latency. A separate write port fills the array. After every reset, a built-in clear sequencer zeroes the whole array before the block accepts traffic. It sits behind any read-interface master, e.g. the nonce/work buffers, as the storage end of the link.

Parameters:
ADDR_WIDTH, 10, read/write address width; DEPTH = 2**ADDR_WIDTH words
DATA_WIDTH, 8, word width
RD_LATENCY, 1, cycles from rdEn sampled to rdData/rdValid updated; legal 1..4, anything else is an elaboration error

Ports:
Clk  input  1  clock, all logic on rising edge
Rst_n  input  1  asynchronous active-low reset
rdEn  input  1  read request, sampled each rising edge
rdAddr  input  ADDR_WIDTH  read address, sampled with rdEn
rdData  output  DATA_WIDTH  read data (slave_mp rdData)
rdValid  output  1  one-cycle pulse: rdData updated this cycle
wrEn  input  1  write strobe
wrAddr  input  ADDR_WIDTH  write address
wrData  input  DATA_WIDTH  write data
initDone  output  1  high once clear sequence has finished

Behaviour:
- Reset (Rst_n low, async): rdData=0, rdValid=0, initDone=0, read pipeline valid bits cleared, clear counter=0, FSM=CLEAR. Array contents are not reset directly; the CLEAR state zeroes them.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[clrCnt] and increments clrCnt. When clrCnt==DEPTH-1 is written, the next state is READY. Clear takes exactly DEPTH cycles after reset deassertion.
  - READY: normal operation; initDone=1 registered, so it rises on the first READY cycle. READY has no exit except reset.
- In CLEAR, rdEn and wrEn are ignored: no pipeline entry, no rdValid, no user write. rdData holds 0.
- Write (READY): wrEn high at edge N -> mem[wrAddr]=wrData at edge N.
- Read (READY): rdEn high at edge N captures rdAddr.
  - Array data (or bypass) enters stage 1 at edge N.
  - It advances one stage per edge.
  - rdData/rdValid are registered from stage RD_LATENCY, so they are visible in the cycle after edge N+RD_LATENCY-1.
  - RD_LATENCY=1: data is visible the cycle after the request.
- Back-to-back reads are allowed every cycle; throughput is 1 word/cycle with no stalls and no backpressure.
- rdValid is high for exactly one cycle per accepted read. With no read emerging, rdValid=0 and rdData holds its last value.
- Read-during-write, same cycle, same address: write-first. The read returns wrData, via a bypass mux at stage-1 capture.
- Read-during-write, different address: no interaction.
- A write landing after the read's stage-1 capture does not alter the in-flight data; the snapshot is taken at capture.
- Reset mid-operation: in-flight reads are discarded (no rdValid), rdData=0, and CLEAR restarts from address 0. Any partially written data is overwritten by the clear.
- Addresses wrap naturally within ADDR_WIDTH. No out-of-range case exists.

Test Plan:
- Config is ADDR_WIDTH=4, DATA_WIDTH=8, RD_LATENCY=2 unless noted.
- Reset release -> initDone low for 16 cycles, high on cycle 17. Read of every address afterwards -> rdData=0x00, with rdValid asserted per read.
- Write 0xA5 to addr 3, then rdEn at addr 3 at edge N -> rdValid=1 and rdData=0xA5 visible after edge N+1. rdValid=0 the following cycle, and rdData stays 0xA5.
- Fill addr i with i+0x10, then stream rdEn for 16 consecutive cycles, addr 0..15 -> 16 consecutive rdValid pulses carrying 0x10..0x1F in order.
- Same cycle: wrEn addr 5 = 0x3C and rdEn addr 5, old value 0x77 -> returned 0x3C. At addr 5, write 0x99 the edge after that read's capture -> the in-flight read still returns 0x3C.
- Assert Rst_n low while 2 reads are in flight and during a write burst -> no rdValid, rdData=0, initDone=0. After release, a 16-cycle clear runs and every address reads 0x00.
- RD_LATENCY=1 and RD_LATENCY=4 builds -> write 0x5A to addr 7, then rdEn at edge N. Data is visible after edge N and edge N+3 respectively. During CLEAR, rdEn produces no rdValid.

Source files
------------

// File: rtl/sram_rd_slave.sv
// sram_rd_slave
// Responder end of the SRAM read interface. Owns a DEPTH-word single-clock
// array that is filled through a dedicated write port and read with a fixed,
// parameterised latency. After every reset a clear sequencer zeroes the whole
// array (one word per cycle) before any user traffic is accepted.
//
// Ports:
//   Clk       in   clock, all logic on rising edge
//   Rst_n     in   asynchronous active-low reset
//   rdEn      in   read request, sampled each rising edge
//   rdAddr    in   read address, sampled with rdEn
//   rdData    out  read data, holds its last value between reads
//   rdValid   out  one-cycle pulse: rdData updated this cycle
//   wrEn      in   write strobe
//   wrAddr    in   write address
//   wrData    in   write data
//   initDone  out  high once the clear sequence has finished
module sram_rd_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  rdEn,
  input  logic [ADDR_WIDTH-1:0] rdAddr,
  output logic [DATA_WIDTH-1:0] rdData,
  output logic                  rdValid,
  input  logic                  wrEn,
  input  logic [ADDR_WIDTH-1:0] wrAddr,
  input  logic [DATA_WIDTH-1:0] wrData,
  output logic                  initDone
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_READY = 1'b1;

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] CNT_ONE  = ADDR_WIDTH'(1'b1);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("sram_rd_slave: RD_LATENCY must be in 1..4");
    end
  endgenerate

  logic                  state_q;
  logic                  state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_d;
  logic                  init_done_q;
  logic                  init_done_d;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_waddr_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  logic                  rd_accept_s;
  logic                  rd_bypass_s;
  logic [DATA_WIDTH-1:0] rd_capture_s;

  // Stage k of the read pipe lives at index k-1; the last stage drives the outputs.
  logic                  pipe_vld_q  [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_data_q [RD_LATENCY];

  // Clear/ready sequencer and the single array write port it shares with users.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_we_s    = 1'b0;
    mem_waddr_s = wrAddr;
    mem_wdata_s = wrData;
    case (state_q)
      ST_CLEAR: begin
        // User writes are ignored while the sequencer owns the port.
        mem_we_s    = 1'b1;
        mem_waddr_s = clr_cnt_q;
        mem_wdata_s = '0;
        clr_cnt_d   = clr_cnt_q + CNT_ONE;
        if (clr_cnt_q == CLR_LAST) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        mem_we_s = wrEn;
        state_d  = ST_READY;
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = '0;
      end
    endcase
    // Registered from next state so initDone rises on the first READY cycle.
    init_done_d = (state_d == ST_READY);
  end

  // Read capture: same-address write in the same cycle wins (write-first).
  always_comb begin
    rd_accept_s  = (state_q == ST_READY) && rdEn;
    rd_bypass_s  = wrEn && (wrAddr == rdAddr);
    rd_capture_s = rd_bypass_s ? wrData : mem_q[rdAddr];
  end

  // Sequencer state registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Storage array; contents are not reset, the clear sequence zeroes them.
  always_ff @(posedge Clk) begin
    if (mem_we_s) begin
      mem_q[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Read pipeline: data only moves alongside a valid bit, so the final
  // stage (and hence rdData) holds its last value between reads.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < RD_LATENCY; k++) begin
        pipe_vld_q[k]  <= 1'b0;
        pipe_data_q[k] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= rd_accept_s;
      if (rd_accept_s) begin
        pipe_data_q[0] <= rd_capture_s;
      end
      for (int k = 1; k < RD_LATENCY; k++) begin
        pipe_vld_q[k] <= pipe_vld_q[k-1];
        if (pipe_vld_q[k-1]) begin
          pipe_data_q[k] <= pipe_data_q[k-1];
        end
      end
    end
  end

  assign rdData   = pipe_data_q[RD_LATENCY-1];
  assign rdValid  = pipe_vld_q[RD_LATENCY-1];
  assign initDone = init_done_q;

endmodule

// File: tb/tb_sram_rd_slave.sv
// tb_sram_rd_slave
// Drives three instances of sram_rd_slave (RD_LATENCY 1, 2 and 4, ADDR_WIDTH 4,
// DATA_WIDTH 8) with identical directed and random traffic. A reference model
// keeps a plain array for memory contents and a per-edge log of accepted reads;
// each instance's expected outputs are looked up from that log at its latency.
module tb_sram_rd_slave;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int HIST  = 4096;
  localparam int NDUT  = 3;

  logic          Clk   = 1'b0;
  logic          Rst_n = 1'b1;
  logic          rdEn  = 1'b0;
  logic [AW-1:0] rdAddr = '0;
  logic          wrEn  = 1'b0;
  logic [AW-1:0] wrAddr = '0;
  logic [DW-1:0] wrData = '0;

  logic [DW-1:0] dut_rd_data  [NDUT];
  logic          dut_rd_valid [NDUT];
  logic          dut_init     [NDUT];

  int lat_tbl [NDUT] = '{1, 2, 4};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [DW-1:0] mdl_mem [DEPTH];
  bit            req_v   [HIST];
  logic [DW-1:0] req_d   [HIST];
  int            edge_cnt  = 0;
  int            since_rel = 0;
  bit            exp_v     [NDUT];
  logic [DW-1:0] exp_d     [NDUT];
  bit            exp_init  = 1'b0;

  always #5 Clk = ~Clk;

  sram_rd_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut_l1 (
    .Clk(Clk), .Rst_n(Rst_n), .rdEn(rdEn), .rdAddr(rdAddr),
    .rdData(dut_rd_data[0]), .rdValid(dut_rd_valid[0]),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .initDone(dut_init[0])
  );

  sram_rd_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_dut_l2 (
    .Clk(Clk), .Rst_n(Rst_n), .rdEn(rdEn), .rdAddr(rdAddr),
    .rdData(dut_rd_data[1]), .rdValid(dut_rd_valid[1]),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .initDone(dut_init[1])
  );

  sram_rd_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(4)) u_dut_l4 (
    .Clk(Clk), .Rst_n(Rst_n), .rdEn(rdEn), .rdAddr(rdAddr),
    .rdData(dut_rd_data[2]), .rdValid(dut_rd_valid[2]),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .initDone(dut_init[2])
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  task automatic check_all();
    for (int j = 0; j < NDUT; j++) begin
      check_val($sformatf("rdValid_L%0d", lat_tbl[j]), 32'(dut_rd_valid[j]), 32'(exp_v[j]));
      check_val($sformatf("rdData_L%0d", lat_tbl[j]), 32'(dut_rd_data[j]), 32'(exp_d[j]));
      check_val($sformatf("initDone_L%0d", lat_tbl[j]), 32'(dut_init[j]), 32'(exp_init));
    end
  endtask

  // Model of one rising edge, using the inputs currently driven.
  task automatic model_edge();
    bit accept;
    int idx;
    edge_cnt++;
    if (!Rst_n) begin
      since_rel       = 0;
      req_v[edge_cnt] = 1'b0;
    end else begin
      accept          = (since_rel >= DEPTH);
      req_v[edge_cnt] = accept && rdEn;
      if (accept && rdEn) begin
        req_d[edge_cnt] = (wrEn && wrAddr == rdAddr) ? wrData : mdl_mem[rdAddr];
      end
      if (accept && wrEn) begin
        mdl_mem[wrAddr] = wrData;
      end
      since_rel++;
    end
    for (int j = 0; j < NDUT; j++) begin
      idx      = edge_cnt - lat_tbl[j] + 1;
      exp_v[j] = Rst_n && (idx >= 1) && req_v[idx];
      if (exp_v[j]) begin
        exp_d[j] = req_d[idx];
      end
    end
    exp_init = Rst_n && (since_rel >= DEPTH);
  endtask

  task automatic cyc(input logic re, input logic [AW-1:0] ra,
                     input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    rdEn   = re;
    rdAddr = ra;
    wrEn   = we;
    wrAddr = wa;
    wrData = wd;
    @(posedge Clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic rand_cyc();
    cyc(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)),
        1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH-1)),
        DW'($urandom_range(0, 255)));
  endtask

  // Asserts reset away from the clock edge, holds it for ncyc edges, releases.
  task automatic do_reset(input int ncyc);
    Rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (edge_cnt - k >= 0) req_v[edge_cnt - k] = 1'b0;
    end
    for (int a = 0; a < DEPTH; a++) mdl_mem[a] = '0;
    for (int j = 0; j < NDUT; j++) begin
      exp_v[j] = 1'b0;
      exp_d[j] = '0;
    end
    since_rel = 0;
    exp_init  = 1'b0;
    check_all();
    for (int c = 0; c < ncyc; c++) begin
      @(posedge Clk);
      model_edge();
      #1;
      check_all();
    end
    Rst_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) mdl_mem[a] = '0;
    for (int j = 0; j < NDUT; j++) begin
      exp_v[j] = 1'b0;
      exp_d[j] = '0;
    end
    #1;
    do_reset(3);

    // Clear phase with random requests that must be ignored.
    for (int c = 0; c < DEPTH; c++) rand_cyc();

    // Every address reads zero after the clear.
    for (int a = 0; a < DEPTH; a++) cyc(1'b1, AW'(a), 1'b0, '0, '0);
    for (int c = 0; c < 5; c++) cyc(1'b0, '0, 1'b0, '0, '0);

    // Single write then read, followed by idle cycles (rdData must hold).
    cyc(1'b0, '0, 1'b1, 4'd3, 8'hA5);
    cyc(1'b1, 4'd3, 1'b0, '0, '0);
    for (int c = 0; c < 5; c++) cyc(1'b0, '0, 1'b0, '0, '0);

    // Fill then stream 16 back-to-back reads.
    for (int a = 0; a < DEPTH; a++) cyc(1'b0, '0, 1'b1, AW'(a), DW'(a + 16));
    for (int a = 0; a < DEPTH; a++) cyc(1'b1, AW'(a), 1'b0, '0, '0);
    for (int c = 0; c < 5; c++) cyc(1'b0, '0, 1'b0, '0, '0);

    // Write-first bypass, then a late write that must not touch the in-flight read.
    cyc(1'b0, '0, 1'b1, 4'd5, 8'h77);
    cyc(1'b1, 4'd5, 1'b1, 4'd5, 8'h3C);
    cyc(1'b0, '0, 1'b1, 4'd5, 8'h99);
    for (int c = 0; c < 5; c++) cyc(1'b0, '0, 1'b0, '0, '0);
    cyc(1'b1, 4'd5, 1'b0, '0, '0);
    for (int c = 0; c < 5; c++) cyc(1'b0, '0, 1'b0, '0, '0);

    // Random mixed traffic.
    for (int c = 0; c < 300; c++) rand_cyc();

    // Reset with reads in flight and a write burst active.
    cyc(1'b1, 4'd1, 1'b1, 4'd9, 8'h11);
    cyc(1'b1, 4'd2, 1'b1, 4'd10, 8'h22);
    do_reset(2);
    for (int c = 0; c < DEPTH; c++) rand_cyc();
    for (int a = 0; a < DEPTH; a++) cyc(1'b1, AW'(a), 1'b0, '0, '0);
    for (int c = 0; c < 5; c++) cyc(1'b0, '0, 1'b0, '0, '0);

    // More random traffic after the second clear.
    for (int c = 0; c < 200; c++) rand_cyc();
    for (int c = 0; c < 5; c++) cyc(1'b0, '0, 1'b0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
